// File: rtl/dcache_2way.sv
// rtl/dcache_2way.sv - two-way set-associative write-back/write-allocate data cache; optional DCACHE_STATS_EN hit/miss counters
module dcache_2way #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int SETS        = 8,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            READ,
  input  logic                            WRITE,
  input  logic [ADDR_W-1:0]               ADDRESS,
  input  logic [DATA_W-1:0]               WRITEDATA,
  output logic [DATA_W-1:0]               READDATA,
  output logic                            BUSYWAIT,
  output logic                            Mem_READ,
  output logic                            Mem_WRITE,
  output logic [ADDR_W-$clog2(BLOCK_WORDS)-1:0] Mem_ADDRESS,
  output logic [DATA_W*BLOCK_WORDS-1:0]   Mem_WRITEDATA,
  input  logic [DATA_W*BLOCK_WORDS-1:0]   Mem_READDATA,
  input  logic                            Mem_BUSYWAIT
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]                     HIT_COUNT,
  output logic [15:0]                     MISS_COUNT
`endif
);

  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int BLK_W = DATA_W * BLOCK_WORDS;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WB    = 2'd1;
  localparam logic [1:0] S_FETCH = 2'd2;
  localparam logic [1:0] S_FILL  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [SETS-1:0]  valid_q [2];
  logic [SETS-1:0]  dirty_q [2];
  logic [SETS-1:0]  lru_q;
  logic [TAG_W-1:0] tag_q   [2][SETS];
  logic [BLK_W-1:0] data_q  [2][SETS];
  logic             victim_q;
  logic [BLK_W-1:0] fill_buf_q;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_off;
  logic             req, do_read, do_write;
  logic [1:0]       hit_w;
  logic             hit, hit_way, idle_hit, victim_sel;

  // Address decode, parallel tag compare of both ways and victim choice
  always_comb begin
    req_tag    = ADDRESS[ADDR_W-1 -: TAG_W];
    req_idx    = ADDRESS[OFF_W +: IDX_W];
    req_off    = ADDRESS[OFF_W-1:0];
    req        = READ | WRITE;
    do_write   = WRITE;
    do_read    = READ & ~WRITE;
    hit_w[0]   = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
    hit_w[1]   = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
    hit        = |hit_w;
    hit_way    = hit_w[1];
    idle_hit   = (state_q == S_IDLE) && hit;
    victim_sel = !valid_q[0][req_idx] ? 1'b0 :
                 !valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx];
  end

  // CPU-side outputs: stall and combinational read data
  always_comb begin
    BUSYWAIT = req && !idle_hit && !RESET;
    READDATA = '0;
    if (do_read && idle_hit)
      READDATA = data_q[hit_way][req_idx][req_off*DATA_W +: DATA_W];
  end

  // Memory-side request outputs, driven only in WRITEBACK and FETCH
  always_comb begin
    Mem_READ      = 1'b0;
    Mem_WRITE     = 1'b0;
    Mem_ADDRESS   = '0;
    Mem_WRITEDATA = '0;
    case (state_q)
      S_WB: begin
        Mem_WRITE     = 1'b1;
        Mem_ADDRESS   = {tag_q[victim_q][req_idx], req_idx};
        Mem_WRITEDATA = data_q[victim_q][req_idx];
      end
      S_FETCH: begin
        Mem_READ    = 1'b1;
        Mem_ADDRESS = {req_tag, req_idx};
      end
      default: ;
    endcase
  end

  // Next-state: misses go through optional write-back, then fetch and fill
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:
        if (req && !hit)
          state_d = (valid_q[victim_sel][req_idx] && dirty_q[victim_sel][req_idx]) ? S_WB : S_FETCH;
      S_WB:    if (!Mem_BUSYWAIT) state_d = S_FETCH;
      S_FETCH: if (!Mem_BUSYWAIT) state_d = S_FILL;
      default: state_d = S_IDLE;
    endcase
  end

  // State, tag/valid/dirty/LRU bookkeeping and block storage updates
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      dirty_q[0] <= '0;
      dirty_q[1] <= '0;
      lru_q      <= '0;
      victim_q   <= 1'b0;
      fill_buf_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE:
          if (req) begin
            if (hit) begin
              lru_q[req_idx] <= ~hit_way;
              if (do_write) begin
                data_q[hit_way][req_idx][req_off*DATA_W +: DATA_W] <= WRITEDATA;
                dirty_q[hit_way][req_idx] <= 1'b1;
              end
            end else begin
              victim_q <= victim_sel;
            end
          end
        S_FETCH:
          if (!Mem_BUSYWAIT) fill_buf_q <= Mem_READDATA;
        S_FILL: begin
          data_q[victim_q][req_idx]  <= fill_buf_q;
          tag_q[victim_q][req_idx]   <= req_tag;
          valid_q[victim_q][req_idx] <= 1'b1;
          dirty_q[victim_q][req_idx] <= 1'b0;
          lru_q[req_idx]             <= ~victim_q;
        end
        default: ;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  // Saturating counters: each cycle a request is served as a hit, and each miss launch
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (req && idle_hit && hit_cnt_q != 16'hFFFF)
        hit_cnt_q <= hit_cnt_q + 16'd1;
      if (state_q == S_IDLE && state_d != S_IDLE && miss_cnt_q != 16'hFFFF)
        miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign HIT_COUNT  = hit_cnt_q;
  assign MISS_COUNT = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_2way.sv
// tb/tb_dcache_2way.sv - randomized self-checking bench for dcache_2way against a recency-list cache model
module tb_dcache_2way;

  logic        CLK = 1'b0;
  logic        RESET, READ, WRITE;
  logic [7:0]  ADDRESS, WRITEDATA, READDATA;
  logic        BUSYWAIT, Mem_READ, Mem_WRITE, Mem_BUSYWAIT;
  logic [5:0]  Mem_ADDRESS;
  logic [31:0] Mem_WRITEDATA, Mem_READDATA;
`ifdef DCACHE_STATS_EN
  logic [15:0] HIT_COUNT, MISS_COUNT;
`endif

  dcache_2way dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
    .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
    .Mem_READ(Mem_READ), .Mem_WRITE(Mem_WRITE), .Mem_ADDRESS(Mem_ADDRESS),
    .Mem_WRITEDATA(Mem_WRITEDATA), .Mem_READDATA(Mem_READDATA), .Mem_BUSYWAIT(Mem_BUSYWAIT)
`ifdef DCACHE_STATS_EN
    , .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  // Block memory: busy for mem_lat cycles after a request appears, then completes
  logic [31:0] mem [0:63];
  int          mem_lat = 1;
  int          mcnt = 0;
  logic [5:0]  wbq_a [$];
  logic [31:0] wbq_d [$];
  logic [5:0]  fq [$];

  assign Mem_BUSYWAIT = (Mem_READ | Mem_WRITE) && (mcnt != mem_lat);
  assign Mem_READDATA = mem[Mem_ADDRESS];

  always @(posedge CLK) begin
    if (RESET) mcnt <= 0;
    else if (Mem_READ | Mem_WRITE) begin
      if (mcnt == mem_lat) begin
        mcnt <= 0;
        if (Mem_WRITE) begin
          mem[Mem_ADDRESS] <= Mem_WRITEDATA;
          wbq_a.push_back(Mem_ADDRESS);
          wbq_d.push_back(Mem_WRITEDATA);
        end else fq.push_back(Mem_ADDRESS);
      end else mcnt <= mcnt + 1;
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: CPU-visible byte image, per-set MRU/LRU block lists, dirty flags
  logic [7:0] gb [0:255];
  int         res_mru [8];
  int         res_lru [8];
  bit         dirtyb [64];

  int          e_stall;
  logic [7:0]  e_rd;
  bit          e_wb, e_fetch;
  logic [5:0]  e_wb_addr;
  logic [31:0] e_wb_data;

  int         o_stall;
  logic [7:0] o_rd;
  logic       o_busy;

  task automatic model_reset();
    for (int s = 0; s < 8; s++) begin res_mru[s] = -1; res_lru[s] = -1; end
    for (int b = 0; b < 64; b++) begin
      dirtyb[b] = 0;
      for (int k = 0; k < 4; k++) gb[b*4+k] = mem[b][k*8 +: 8];
    end
  endtask

  task automatic model_access(input bit wr, input logic [7:0] a, input logic [7:0] wd);
    int b, s, ev;
    b = int'(a) / 4;
    s = b % 8;
    e_wb = 0; e_wb_addr = '0; e_wb_data = '0;
    e_fetch = !((res_mru[s] == b) || (res_lru[s] == b));
    if (!e_fetch) begin
      if (res_lru[s] == b) begin res_lru[s] = res_mru[s]; res_mru[s] = b; end
      e_stall = 0;
    end else begin
      if (res_mru[s] >= 0 && res_lru[s] >= 0) begin
        ev = res_lru[s];
        if (dirtyb[ev]) begin
          e_wb = 1;
          e_wb_addr = 6'(ev);
          e_wb_data = {gb[ev*4+3], gb[ev*4+2], gb[ev*4+1], gb[ev*4]};
          dirtyb[ev] = 0;
        end
      end
      res_lru[s] = res_mru[s];
      res_mru[s] = b;
      dirtyb[b] = 0;
      e_stall = 3 + mem_lat + (e_wb ? mem_lat + 1 : 0);
    end
    if (wr) begin gb[a] = wd; dirtyb[b] = 1; e_rd = 8'h00; end
    else e_rd = gb[a];
  endtask

  task automatic access(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] wd);
    model_access(wr, a, wd);
    wbq_a.delete(); wbq_d.delete(); fq.delete();
    @(negedge CLK);
    READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = wd;
    o_stall = 0;
    #1;
    o_busy = BUSYWAIT;
    while (BUSYWAIT && o_stall < 200) begin
      @(posedge CLK);
      o_stall++;
      @(negedge CLK);
      #1;
    end
    o_rd = READDATA;
    @(posedge CLK);
    #1;
    READ = 1'b0; WRITE = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1; READ = 1'b0; WRITE = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RESET = 1'b1; READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h05; WRITEDATA = 8'h00;
    #1;
    n_cmp++; if (BUSYWAIT !== 1'b0) begin n_fail++; $display("FAIL reset_busywait got=%b exp=0", BUSYWAIT); end
    @(posedge CLK);
    #1;
    n_cmp++; if (Mem_READ !== 1'b0) begin n_fail++; $display("FAIL reset_mem_read got=%b exp=0", Mem_READ); end
    n_cmp++; if (Mem_WRITE !== 1'b0) begin n_fail++; $display("FAIL reset_mem_write got=%b exp=0", Mem_WRITE); end
    n_cmp++; if (Mem_ADDRESS !== 6'h00) begin n_fail++; $display("FAIL reset_mem_addr got=%h exp=00", Mem_ADDRESS); end
    n_cmp++; if (Mem_WRITEDATA !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata got=%h exp=0", Mem_WRITEDATA); end
    n_cmp++; if (READDATA !== 8'h00) begin n_fail++; $display("FAIL reset_readdata got=%h exp=00", READDATA); end
    READ = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    model_reset();
  endtask

  task automatic test_read_miss();
    mem_lat = 2;
    access(1, 0, 8'h05, 8'h00);
    n_cmp++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL miss_busy got=%b exp=1", o_busy); end
    n_cmp++; if (fq.size() != 1 || fq[0] !== 6'h01) begin n_fail++; $display("FAIL miss_fetch_addr n=%0d exp 1 fetch of 01", fq.size()); end
    n_cmp++; if (o_stall != 5) begin n_fail++; $display("FAIL miss_stall got=%0d exp=5", o_stall); end
    n_cmp++; if (o_rd !== 8'hBB) begin n_fail++; $display("FAIL miss_readdata got=%h exp=bb", o_rd); end
  endtask

  task automatic test_write_hit();
    access(0, 1, 8'h06, 8'h5A);
    n_cmp++; if (o_stall != 0) begin n_fail++; $display("FAIL wrhit_stall got=%0d exp=0", o_stall); end
    n_cmp++; if (wbq_a.size() != 0 || fq.size() != 0) begin n_fail++; $display("FAIL wrhit_mem_traffic wb=%0d fetch=%0d exp=0", wbq_a.size(), fq.size()); end
    access(1, 0, 8'h06, 8'h00);
    n_cmp++; if (o_rd !== 8'h5A || o_stall != 0) begin n_fail++; $display("FAIL wrhit_readback got=%h stall=%0d exp=5a stall=0", o_rd, o_stall); end
  endtask

  task automatic test_conflict();
    logic [7:0] b04;
    do_reset();
    mem_lat = 1;
    b04 = mem[1][7:0];
    access(1, 0, 8'h04, 8'h00);
    access(1, 0, 8'h24, 8'h00);
    n_cmp++; if (fq.size() != 1 || fq[0] !== 6'h09 || o_stall != 4) begin n_fail++; $display("FAIL conf_fill_way1 n=%0d stall=%0d exp fetch 09 stall 4", fq.size(), o_stall); end
    access(1, 0, 8'h04, 8'h00);
    n_cmp++; if (o_stall != 0 || o_rd !== b04) begin n_fail++; $display("FAIL conf_hit04 stall=%0d rd=%h exp stall=0 rd=%h", o_stall, o_rd, b04); end
    access(1, 0, 8'h44, 8'h00);
    n_cmp++; if (fq.size() != 1 || fq[0] !== 6'h11 || wbq_a.size() != 0) begin n_fail++; $display("FAIL conf_miss44 fetch=%0d wb=%0d exp 1 fetch of 11, 0 wb", fq.size(), wbq_a.size()); end
`ifdef DCACHE_STATS_EN
    n_cmp++; if (HIT_COUNT !== 16'd4) begin n_fail++; $display("FAIL stats_hit got=%0d exp=4", HIT_COUNT); end
    n_cmp++; if (MISS_COUNT !== 16'd3) begin n_fail++; $display("FAIL stats_miss got=%0d exp=3", MISS_COUNT); end
`endif
    access(1, 0, 8'h04, 8'h00);
    n_cmp++; if (o_stall != 0) begin n_fail++; $display("FAIL conf_rehit04 stall=%0d exp=0", o_stall); end
    access(1, 0, 8'h24, 8'h00);
    n_cmp++; if (o_stall != 4) begin n_fail++; $display("FAIL conf_24_evicted stall=%0d exp=4", o_stall); end
  endtask

  task automatic test_dirty_evict();
    logic [31:0] exp_blk;
    do_reset();
    mem_lat = 2;
    exp_blk = {mem[9][31:8], 8'hC3};
    access(1, 0, 8'h04, 8'h00);
    access(1, 0, 8'h24, 8'h00);
    access(0, 1, 8'h24, 8'hC3);
    access(1, 0, 8'h04, 8'h00);
    access(1, 0, 8'h44, 8'h00);
    n_cmp++; if (wbq_a.size() != 1 || wbq_a[0] !== 6'h09) begin n_fail++; $display("FAIL dirty_wb_addr n=%0d exp 1 write-back to 09", wbq_a.size()); end
    n_cmp++; if (wbq_d.size() != 1 || wbq_d[0] !== exp_blk) begin n_fail++; $display("FAIL dirty_wb_data exp=%h", exp_blk); end
    n_cmp++; if (fq.size() != 1 || fq[0] !== 6'h11) begin n_fail++; $display("FAIL dirty_fetch_addr n=%0d exp 1 fetch of 11", fq.size()); end
    n_cmp++; if (o_stall != 8) begin n_fail++; $display("FAIL dirty_stall got=%0d exp=8", o_stall); end
  endtask

  task automatic test_reset_mid_fetch();
    int n;
    do_reset();
    mem_lat = 3;
    fq.delete();
    @(negedge CLK);
    READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h45;
    n = 0;
    #1;
    while (!Mem_READ && n < 20) begin @(negedge CLK); #1; n++; end
    n_cmp++; if (Mem_READ !== 1'b1) begin n_fail++; $display("FAIL rstfetch_reached got=%b exp=1", Mem_READ); end
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    n_cmp++; if (Mem_READ !== 1'b0 || BUSYWAIT !== 1'b0) begin n_fail++; $display("FAIL rstfetch_deassert mem_read=%b busy=%b exp 0 0", Mem_READ, BUSYWAIT); end
    READ = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    model_reset();
    n_cmp++; if (fq.size() != 0) begin n_fail++; $display("FAIL rstfetch_no_fetch got=%0d exp=0", fq.size()); end
    access(1, 0, 8'h45, 8'h00);
    n_cmp++; if (o_stall != 6 || fq.size() != 1) begin n_fail++; $display("FAIL rstfetch_remiss stall=%0d fetches=%0d exp 6 1", o_stall, fq.size()); end
  endtask

  task automatic test_random();
    int op, t;
    logic [7:0] a, wd;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      mem_lat = $urandom_range(1, 3);
      op = $urandom_range(0, 3);
      t = $urandom_range(0, 3);
      a = 8'(t * 32 + int'($urandom_range(0, 31)));
      wd = 8'($urandom);
      access(op != 2, op >= 2, a, wd);
      n_cmp++; if (o_stall != e_stall) begin n_fail++; $display("FAIL rand_stall i=%0d a=%h got=%0d exp=%0d", i, a, o_stall, e_stall); end
      n_cmp++; if (o_rd !== e_rd) begin n_fail++; $display("FAIL rand_readdata i=%0d a=%h got=%h exp=%h", i, a, o_rd, e_rd); end
      n_cmp++; if (o_busy !== (e_stall != 0)) begin n_fail++; $display("FAIL rand_busy i=%0d got=%b exp=%b", i, o_busy, e_stall != 0); end
      n_cmp++; if (wbq_a.size() != int'(e_wb)) begin n_fail++; $display("FAIL rand_wb_count i=%0d got=%0d exp=%0d", i, wbq_a.size(), e_wb); end
      else if (e_wb) begin
        n_cmp++; if (wbq_a[0] !== e_wb_addr || wbq_d[0] !== e_wb_data) begin n_fail++; $display("FAIL rand_wb i=%0d got=%h/%h exp=%h/%h", i, wbq_a[0], wbq_d[0], e_wb_addr, e_wb_data); end
      end
      n_cmp++; if (fq.size() != int'(e_fetch)) begin n_fail++; $display("FAIL rand_fetch_count i=%0d got=%0d exp=%0d", i, fq.size(), e_fetch); end
      else if (e_fetch) begin
        n_cmp++; if (fq[0] !== a[7:2]) begin n_fail++; $display("FAIL rand_fetch_addr i=%0d got=%h exp=%h", i, fq[0], a[7:2]); end
      end
    end
  endtask

  initial begin
    RESET = 1'b0; READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[1] = 32'hDDCCBBAA;
    test_reset();
    test_read_miss();
    test_write_hit();
    test_conflict();
    test_dirty_evict();
    test_reset_mid_fetch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
